// File: rtl/spi_flash_boot_ctrl.sv
// spi_flash_boot_ctrl: boot sequencer that copies BOOT_WORDS 32-bit words
// from an SPI NOR flash (READ 0x03, SPI mode 0) into instruction memory while
// holding the core in reset, then releases the core.
//
// Bit engine: every SPI bit is a low half-period followed by a high
// half-period, each CLK_DIV clk cycles long. MOSI only moves when SCLK falls.
// MISO is captured on the clk edge that raises SCLK. The imem write for a
// word is issued one cycle after its last bit is captured, while SCLK keeps
// running into the next word.

module spi_flash_boot_ctrl #(
    parameter int          BOOT_WORDS  = 1024,
    parameter logic [23:0] FLASH_BASE  = 24'h000000,
    parameter int          CLK_DIV     = 1,
    parameter int          IMEM_ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_boot_bypass,
    output logic                   o_flash_sclk,
    output logic                   o_flash_cs_n,
    output logic                   o_flash_mosi,
    input  logic                   i_flash_miso,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_core_reset_n,
    output logic                   o_boot_done
);

    // Counter widths: the divider counts 0..CLK_DIV-1, the word counter
    // counts 0..BOOT_WORDS-1.
    localparam int DIV_W  = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int WORD_W = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BOOT_WORDS - 1);
    localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};
    localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1);
    localparam logic [31:0]       CMD_FRAME = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CMD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Flash bytes arrive MSB-first and are packed little-endian: the first
    // byte received (top of the shift register) lands in bits [7:0].
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t                   state_r;
    logic                     run_r;
    logic [DIV_W-1:0]         div_cnt_r;
    logic [4:0]               bit_cnt_r;
    logic [WORD_W-1:0]        word_cnt_r;
    logic [31:0]              shift_r;
    logic [31:0]              rx_r;
    logic                     wr_pend_r;
    logic                     sclk_r;
    logic                     cs_n_r;
    logic                     mosi_r;
    logic                     imem_we_r;
    logic [IMEM_ADDR_W-1:0]   imem_addr_r;
    logic [31:0]              imem_wdata_r;
    logic                     core_reset_n_r;
    logic                     boot_done_r;

    // Boot sequencer: state, SPI bit engine, word assembly and imem strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            run_r          <= 1'b0;
            div_cnt_r      <= DIV_ZERO;
            bit_cnt_r      <= 5'd0;
            word_cnt_r     <= WORD_ZERO;
            shift_r        <= 32'h0000_0000;
            rx_r           <= 32'h0000_0000;
            wr_pend_r      <= 1'b0;
            sclk_r         <= 1'b0;
            cs_n_r         <= 1'b1;
            mosi_r         <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= {IMEM_ADDR_W{1'b0}};
            imem_wdata_r   <= 32'h0000_0000;
            core_reset_n_r <= 1'b0;
            boot_done_r    <= 1'b0;
        end else begin
            // Write strobe: one cycle after the last bit of a word is captured.
            // Address and data hold after the strobe drops.
            imem_we_r <= 1'b0;
            wr_pend_r <= 1'b0;
            if (wr_pend_r) begin
                imem_we_r    <= 1'b1;
                imem_addr_r  <= IMEM_ADDR_W'(word_cnt_r);
                imem_wdata_r <= byte_swap(rx_r);
            end else begin
                imem_we_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    // The first cycle out of reset only arms the sequencer, so
                    // IDLE occupies one full cycle before bypass is sampled.
                    if (!run_r) begin
                        run_r <= 1'b1;
                    end else if (i_boot_bypass) begin
                        state_r        <= ST_DONE;
                        boot_done_r    <= 1'b1;
                        core_reset_n_r <= 1'b1;
                    end else begin
                        state_r   <= ST_CS_SETUP;
                        cs_n_r    <= 1'b0;
                        mosi_r    <= CMD_FRAME[31];
                        shift_r   <= CMD_FRAME;
                        div_cnt_r <= DIV_ZERO;
                    end
                end

                ST_CS_SETUP: begin
                    // CS low with SCLK low for CLK_DIV cycles, first bit on MOSI.
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= DIV_ZERO;
                        bit_cnt_r <= 5'd0;
                        state_r   <= ST_CMD;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end

                ST_CMD: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= DIV_ZERO;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else begin
                            // Falling edge closes the bit and presents the next one.
                            sclk_r <= 1'b0;
                            if (bit_cnt_r == 5'd31) begin
                                bit_cnt_r <= 5'd0;
                                mosi_r    <= 1'b0;
                                state_r   <= ST_DATA;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                                mosi_r    <= shift_r[30];
                                shift_r   <= {shift_r[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end

                ST_DATA: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= DIV_ZERO;
                        if (!sclk_r) begin
                            // Rising edge: capture MISO, flag a complete word.
                            sclk_r <= 1'b1;
                            rx_r   <= {rx_r[30:0], i_flash_miso};
                            if (bit_cnt_r == 5'd31) begin
                                wr_pend_r <= 1'b1;
                            end else begin
                                wr_pend_r <= 1'b0;
                            end
                        end else begin
                            sclk_r <= 1'b0;
                            if (bit_cnt_r == 5'd31) begin
                                // Word boundary. The strobe for this word reads
                                // word_cnt_r on or before this edge.
                                bit_cnt_r <= 5'd0;
                                if (word_cnt_r == WORD_LAST) begin
                                    state_r <= ST_CS_HOLD;
                                end else begin
                                    word_cnt_r <= word_cnt_r + WORD_ONE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end

                ST_CS_HOLD: begin
                    // Hold CS low with SCLK low for CLK_DIV cycles, then release.
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r      <= DIV_ZERO;
                        state_r        <= ST_DONE;
                        cs_n_r         <= 1'b1;
                        mosi_r         <= 1'b0;
                        boot_done_r    <= 1'b1;
                        core_reset_n_r <= 1'b1;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end

                ST_DONE: begin
                    cs_n_r         <= 1'b1;
                    sclk_r         <= 1'b0;
                    mosi_r         <= 1'b0;
                    boot_done_r    <= 1'b1;
                    core_reset_n_r <= 1'b1;
                end

                default: begin
                    // Unreachable encodings park the sequencer safely with
                    // the core still held in reset.
                    state_r        <= ST_IDLE;
                    run_r          <= 1'b0;
                    cs_n_r         <= 1'b1;
                    sclk_r         <= 1'b0;
                    mosi_r         <= 1'b0;
                    core_reset_n_r <= 1'b0;
                    boot_done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign o_flash_sclk   = sclk_r;
    assign o_flash_cs_n   = cs_n_r;
    assign o_flash_mosi   = mosi_r;
    assign o_imem_we      = imem_we_r;
    assign o_imem_addr    = imem_addr_r;
    assign o_imem_wdata   = imem_wdata_r;
    assign o_core_reset_n = core_reset_n_r;
    assign o_boot_done    = boot_done_r;

endmodule

// File: tb/tb_spi_flash_boot_ctrl.sv
// Scoreboard bench for spi_flash_boot_ctrl. Two instances share clock and
// reset: A (CLK_DIV=1, 2 words, base 0x010203) and B (CLK_DIV=3, 1 word).
// Expected writes are queued when a run is started; a monitor pops and
// compares on every imem write strobe. Expected timing follows the bit
// timing: done at T+1+CLK_DIV*(2+64+64*BOOT_WORDS).

module tb_spi_flash_boot_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic bypass;

    logic        a_sclk, a_cs_n, a_mosi, a_miso, a_we, a_core, a_done;
    logic [15:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_sclk, b_cs_n, b_mosi, b_miso, b_we, b_core, b_done;
    logic [15:0] b_addr;
    logic [31:0] b_wdata;

    spi_flash_boot_ctrl #(.BOOT_WORDS(2), .FLASH_BASE(24'h010203), .CLK_DIV(1), .IMEM_ADDR_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_boot_bypass(bypass),
        .o_flash_sclk(a_sclk), .o_flash_cs_n(a_cs_n), .o_flash_mosi(a_mosi), .i_flash_miso(a_miso),
        .o_imem_we(a_we), .o_imem_addr(a_addr), .o_imem_wdata(a_wdata),
        .o_core_reset_n(a_core), .o_boot_done(a_done));

    spi_flash_boot_ctrl #(.BOOT_WORDS(1), .FLASH_BASE(24'h000000), .CLK_DIV(3), .IMEM_ADDR_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_boot_bypass(bypass),
        .o_flash_sclk(b_sclk), .o_flash_cs_n(b_cs_n), .o_flash_mosi(b_mosi), .i_flash_miso(b_miso),
        .o_imem_we(b_we), .o_imem_addr(b_addr), .o_imem_wdata(b_wdata),
        .o_core_reset_n(b_core), .o_boot_done(b_done));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t ea, eb;

    logic [7:0] a_mem [0:7];
    logic [7:0] b_mem [0:3];

    // Flash model and observation state
    int a_rises, a_mosi_err, b_rises, b_mosi_err;
    logic [31:0] a_cmd, b_cmd;
    int a_fall, a_rise, a_done_cyc, a_wecnt, a_hold_err, a_tog;
    int b_fall, b_rise, b_done_cyc, b_wecnt, b_hold_err, b_tog;
    int b_run, b_phase_err, b_phase_n;
    logic a_prev_sclk, b_prev_sclk, b_seen_high;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Flash A: capture command bits on SCLK rise, shift data out on SCLK fall.
    always @(posedge a_sclk) begin
        if (a_cs_n === 1'b0) begin
            if (a_rises < 32) a_cmd = {a_cmd[30:0], a_mosi};
            else if (a_mosi !== 1'b0) a_mosi_err++;
            a_rises++;
        end
    end
    always @(negedge a_sclk) begin
        if (a_cs_n === 1'b0 && a_rises >= 32 && a_rises < 32 + 64)
            a_miso = a_mem[(a_rises - 32) / 8][7 - ((a_rises - 32) % 8)];
    end

    // Flash B
    always @(posedge b_sclk) begin
        if (b_cs_n === 1'b0) begin
            if (b_rises < 32) b_cmd = {b_cmd[30:0], b_mosi};
            else if (b_mosi !== 1'b0) b_mosi_err++;
            b_rises++;
        end
    end
    always @(negedge b_sclk) begin
        if (b_cs_n === 1'b0 && b_rises >= 32 && b_rises < 32 + 32)
            b_miso = b_mem[(b_rises - 32) / 8][7 - ((b_rises - 32) % 8)];
    end

    // Monitor: scoreboard pops on write strobes plus per-cycle observations.
    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            a_wecnt++;
            if (exp_a.size() == 0) chk("a_wr_unexpected", 64'(exp_a.size()), 64'd1);
            else begin
                ea = exp_a.pop_front();
                chk("a_wr_addr", a_addr, ea.addr);
                chk("a_wr_data", a_wdata, ea.data);
            end
        end
        if (b_we === 1'b1) begin
            b_wecnt++;
            if (exp_b.size() == 0) chk("b_wr_unexpected", 64'(exp_b.size()), 64'd1);
            else begin
                eb = exp_b.pop_front();
                chk("b_wr_addr", b_addr, eb.addr);
                chk("b_wr_data", b_wdata, eb.data);
            end
        end
        if (a_core !== a_done) a_hold_err++;
        if (b_core !== b_done) b_hold_err++;
        if (a_cs_n === 1'b0 && a_fall < 0) a_fall = cyc;
        if (a_cs_n === 1'b1 && a_fall >= 0 && a_rise < 0) a_rise = cyc;
        if (a_done === 1'b1 && a_done_cyc < 0) a_done_cyc = cyc;
        if (b_cs_n === 1'b0 && b_fall < 0) b_fall = cyc;
        if (b_cs_n === 1'b1 && b_fall >= 0 && b_rise < 0) b_rise = cyc;
        if (b_done === 1'b1 && b_done_cyc < 0) b_done_cyc = cyc;
        if (a_sclk !== a_prev_sclk) a_tog++;
        a_prev_sclk = a_sclk;
        if (b_sclk !== b_prev_sclk) begin
            b_tog++;
            if (b_prev_sclk === 1'b1 || b_seen_high) begin
                b_phase_n++;
                if (b_run != 3) b_phase_err++;
            end
            if (b_prev_sclk === 1'b1) b_seen_high = 1'b1;
            b_run = 1;
        end else begin
            b_run++;
        end
        b_prev_sclk = b_sclk;
    end

    task automatic reset_model();
        a_rises = 0; a_mosi_err = 0; a_cmd = 32'h0; a_miso = 1'b0;
        b_rises = 0; b_mosi_err = 0; b_cmd = 32'h0; b_miso = 1'b0;
    endtask

    task automatic clear_obs();
        a_fall = -1; a_rise = -1; a_done_cyc = -1; a_wecnt = 0; a_hold_err = 0; a_tog = 0;
        b_fall = -1; b_rise = -1; b_done_cyc = -1; b_wecnt = 0; b_hold_err = 0; b_tog = 0;
        a_prev_sclk = a_sclk; b_prev_sclk = b_sclk;
        b_run = 0; b_phase_err = 0; b_phase_n = 0; b_seen_high = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_a"}, {a_cs_n, a_sclk, a_mosi, a_we, a_addr, a_wdata, a_core, a_done},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0});
        chk({tag, "_rst_b"}, {b_cs_n, b_sclk, b_mosi, b_we, b_addr, b_wdata, b_core, b_done},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0});
    endtask

    // Assert reset, check reset values, then release on a falling clk edge.
    task automatic start_run(input logic bp, input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        bypass = bp;
        #1;
        chk_reset_vals(tag);
        reset_model();
        clear_obs();
        repeat (3) @(negedge clk);
        t0 = cyc + 1;
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !(a_done === 1'b1 && b_done === 1'b1); i++) @(negedge clk);
        chk("run_complete", {a_done, b_done}, 2'b11);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_copy(input string tag);
        chk({tag, "_a_cs_fall"}, a_fall, t0 + 1);
        chk({tag, "_a_done_cyc"}, a_done_cyc, t0 + 1 + 194);
        chk({tag, "_a_cs_rise"}, a_rise, t0 + 1 + 194);
        chk({tag, "_a_we_count"}, a_wecnt, 2);
        chk({tag, "_a_sclk_rises"}, a_rises, 96);
        chk({tag, "_a_cmd_frame"}, a_cmd, 32'h0301_0203);
        chk({tag, "_a_mosi_zero"}, a_mosi_err, 0);
        chk({tag, "_a_core_hold"}, a_hold_err, 0);
        chk({tag, "_a_queue_empty"}, exp_a.size(), 0);
        chk({tag, "_b_cs_fall"}, b_fall, t0 + 1);
        chk({tag, "_b_done_cyc"}, b_done_cyc, t0 + 1 + 390);
        chk({tag, "_b_cs_low_len"}, b_rise - b_fall, 390);
        chk({tag, "_b_we_count"}, b_wecnt, 1);
        chk({tag, "_b_sclk_rises"}, b_rises, 64);
        chk({tag, "_b_cmd_frame"}, b_cmd, 32'h0300_0000);
        chk({tag, "_b_mosi_zero"}, b_mosi_err, 0);
        chk({tag, "_b_core_hold"}, b_hold_err, 0);
        chk({tag, "_b_queue_empty"}, exp_b.size(), 0);
        chk({tag, "_b_phase_count"}, b_phase_n, 127);
        chk({tag, "_b_phase_len"}, b_phase_err, 0);
        chk({tag, "_final_pins"}, {a_cs_n, a_sclk, a_core, b_cs_n, b_sclk, b_core}, 6'b101101);
    endtask

    initial begin
        a_mem[0] = 8'h78; a_mem[1] = 8'h56; a_mem[2] = 8'h34; a_mem[3] = 8'h12;
        a_mem[4] = 8'hEF; a_mem[5] = 8'hBE; a_mem[6] = 8'hAD; a_mem[7] = 8'hDE;
        b_mem[0] = 8'hA5; b_mem[1] = 8'h5A; b_mem[2] = 8'hC3; b_mem[3] = 8'h3C;
        reset_n = 1'b0;
        bypass = 1'b0;
        reset_model();
        clear_obs();

        // Normal copy on both instances
        exp_a.push_back(wr_t'{addr: 16'd0, data: 32'h1234_5678});
        exp_a.push_back(wr_t'{addr: 16'd1, data: 32'hDEAD_BEEF});
        exp_b.push_back(wr_t'{addr: 16'd0, data: 32'h3CC3_5AA5});
        start_run(1'b0, "norm");
        wait_done(2000);
        check_copy("norm");

        // Bypass: done at T+1, flash pins idle, no writes
        start_run(1'b1, "byp");
        @(negedge clk);
        chk("byp_state_at_T", {a_done, a_core, b_done, b_core}, 4'b0000);
        @(negedge clk);
        chk("byp_state_at_T1", {a_done, a_core, b_done, b_core}, 4'b1111);
        repeat (40) @(negedge clk);
        chk("byp_a_cs_fall", a_fall, -1);
        chk("byp_b_cs_fall", b_fall, -1);
        chk("byp_sclk_toggles", a_tog + b_tog, 0);
        chk("byp_writes", a_wecnt + b_wecnt, 0);
        chk("byp_mosi", {a_mosi, b_mosi}, 2'b00);

        // Reset during the 10th data bit of word 1 on instance A
        exp_a.push_back(wr_t'{addr: 16'd0, data: 32'h1234_5678});
        start_run(1'b0, "mid");
        for (int i = 0; i < 500 && a_rises < 74; i++) @(negedge clk);
        chk("mid_reached_bit", a_rises, 74);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_abort");
        chk("mid_first_word_written", a_wecnt, 1);
        chk("mid_queue_drained", exp_a.size(), 0);
        exp_a.push_back(wr_t'{addr: 16'd0, data: 32'h1234_5678});
        exp_a.push_back(wr_t'{addr: 16'd1, data: 32'hDEAD_BEEF});
        exp_b.push_back(wr_t'{addr: 16'd0, data: 32'h3CC3_5AA5});
        start_run(1'b0, "restart");
        wait_done(2000);
        check_copy("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
